// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction-cache controller in front of one cache_ram data array.
// Ports: cpu_req_* / cpu_resp_* fetch side (one pack per request); mem_req_* / mem_resp_* line refill,
//        DATA_LEN beats with pack 0 first; ram_* drive cache_ram (one-hot pack select); flush invalidates all lines.
module icache_ctrl #(
  parameter int DATA_LEN   = 4,
  parameter int DATA_PACK  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM   = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic                            cpu_req_valid,
  input  logic [PC_WIDTH-1:0]             cpu_req_addr,
  output logic                            cpu_req_ready,
  output logic                            cpu_resp_valid,
  output logic [DATA_WIDTH*DATA_PACK-1:0] cpu_resp_data,
  input  logic                            flush,
  output logic                            mem_req_valid,
  output logic [PC_WIDTH-1:0]             mem_req_addr,
  input  logic                            mem_req_ready,
  input  logic                            mem_resp_valid,
  input  logic [DATA_WIDTH*DATA_PACK-1:0] mem_resp_data,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH*DATA_PACK-1:0] ram_wdata,
  output logic [DATA_LEN-1:0]             ram_ren,
  output logic [DATA_LEN-1:0]             ram_wen,
  input  logic [DATA_WIDTH*DATA_PACK-1:0] ram_rdata
);

  localparam int PACK_W = DATA_WIDTH * DATA_PACK;
  localparam int OFF_W  = $clog2(PACK_W / 8);
  localparam int WRD_W  = $clog2(DATA_LEN);
  localparam int TAG_W  = PC_WIDTH - OFF_W - WRD_W - ADDR_WIDTH;
  localparam int CNT_W  = WRD_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MISS_REQ = 2'd2,
    REFILL   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_NUM-1:0]   valid;
  logic [TAG_W-1:0]      tag_mem [DATA_NUM];
  logic [TAG_W-1:0]      req_tag;
  logic [ADDR_WIDTH-1:0] req_index;
  logic [WRD_W-1:0]      req_word;
  logic [CNT_W-1:0]      cnt;
  logic                  flush_pend;

  logic accept;
  logic hit;
  logic beat;
  logic last_beat;
  logic unused_off;

  // Byte offset within a pack never matters: the cache always returns a whole pack.
  assign unused_off = ^cpu_req_addr[OFF_W-1:0];

  assign accept    = (state == IDLE) && cpu_req_valid;
  assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign beat      = (state == REFILL) && mem_resp_valid;
  assign last_beat = beat && (cnt == CNT_W'(DATA_LEN - 1));

  // The latched line address stays put for the whole miss, so the refill address is stable by construction.
  assign mem_req_addr = {req_tag, req_index, {(OFF_W + WRD_W){1'b0}}};

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state          <= IDLE;
      valid          <= '0;
      req_tag        <= '0;
      req_index      <= '0;
      req_word       <= '0;
      cnt            <= '0;
      flush_pend     <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_data  <= '0;
    end else begin
      state          <= state_nxt;
      cpu_resp_valid <= 1'b0;

      if (accept) begin
        req_tag   <= cpu_req_addr[PC_WIDTH-1 -: TAG_W];
        req_index <= cpu_req_addr[OFF_W+WRD_W +: ADDR_WIDTH];
        req_word  <= cpu_req_addr[OFF_W +: WRD_W];
      end

      if ((state == LOOKUP) && hit) begin
        cpu_resp_data  <= ram_rdata;
        cpu_resp_valid <= 1'b1;
      end

      if ((state == MISS_REQ) && mem_req_ready) begin
        cnt <= '0;
      end

      if (beat) begin
        cnt <= cnt + 1'b1;
        // Critical word is only captured here; it is returned after the whole line lands.
        if (cnt[WRD_W-1:0] == req_word) begin
          cpu_resp_data <= mem_resp_data;
        end
      end

      if (flush) begin
        valid <= '0;
      end

      // A flush seen at any point of the refill (or on its final beat) leaves the new line invalid.
      if (last_beat) begin
        valid[req_index] <= !(flush_pend || flush);
        flush_pend       <= 1'b0;
        cpu_resp_valid   <= 1'b1;
      end else if (flush && ((state == MISS_REQ) || (state == REFILL))) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Tag contents need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_mem[req_index] <= req_tag;
    end
  end

  always_comb begin
    state_nxt     = state;
    cpu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ram_addr      = '0;
    ram_ren       = '0;
    ram_wen       = '0;
    ram_wdata     = '0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        ram_addr  = req_index;
        ram_ren   = DATA_LEN'(1) << req_word;
        state_nxt = hit ? IDLE : MISS_REQ;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        if (mem_resp_valid) begin
          ram_addr  = req_index;
          ram_wen   = DATA_LEN'(1) << cnt[WRD_W-1:0];
          ram_wdata = mem_resp_data;
          if (last_beat) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl with a cache_ram model and a scripted memory responder.
// Directed vectors come from a table, then random fetches are checked against a line-level hit/miss model.
module tb_icache_ctrl;

  logic        clk;
  logic        srst_n;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [5:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [3:0]  ram_ren;
  logic [3:0]  ram_wen;
  logic [63:0] ram_rdata;

  int total;
  int bad;

  icache_ctrl dut (
    .clk            (clk),
    .srst_n         (srst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_ren        (ram_ren),
    .ram_wen        (ram_wen),
    .ram_rdata      (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cache_ram model: registered write per pack, combinational read
  logic [63:0] ram_mem [64][4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wen[i]) ram_mem[ram_addr][i] <= ram_wdata;
    end
  end
  always_comb begin
    ram_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (ram_ren[i]) ram_rdata = ram_mem[ram_addr][i];
    end
  end

  // Backing memory contents: every pack of every line is distinct.
  function automatic logic [63:0] pack_of(input logic [31:0] line, input int p);
    return {line | 32'(p), ~line ^ (32'(p) * 32'd3 + 32'd1)};
  endfunction

  typedef struct {
    logic [31:0] addr;
    bit          flush_acc;
    int          rdy;
    int          gap;
    int          fbeat;
    int          rbeat;
    bit          exp_hit;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input bit fa, input int rdy, input int gap,
                              input int fb, input int rb, input bit eh);
    vec_t v;
    v.addr = a; v.flush_acc = fa; v.rdy = rdy; v.gap = gap;
    v.fbeat = fb; v.rbeat = rb; v.exp_hit = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
    check("rst_resp_data", cpu_resp_data, 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_ram_ren", 64'(ram_ren), 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
  endtask

  // Line-level reference: which line each set holds and whether it is valid.
  bit ref_valid [64];
  int ref_tag   [64];

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic model_access(input vec_t v, output bit hit);
    int idx;
    int tg;
    idx = int'((v.addr >> 5) & 32'h3F);
    tg  = int'(v.addr >> 11);
    if (v.flush_acc) model_clear();
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    if (!hit) begin
      if (v.rbeat >= 0) begin
        model_clear();
      end else begin
        if (v.fbeat >= 0) model_clear();
        ref_tag[idx]   = tg;
        ref_valid[idx] = (v.fbeat < 0);
      end
    end
  endtask

  // Issues one fetch starting at a falling edge; ends at the falling edge where the response is seen.
  task automatic fetch(input vec_t v, output bit miss, output logic [63:0] data);
    logic [31:0] line;
    int idx;
    int wrd;
    line = v.addr & ~32'h1F;
    idx  = int'((v.addr >> 5) & 32'h3F);
    wrd  = int'((v.addr >> 3) & 32'h3);
    miss = 1'b0;
    data = '0;
    check("req_ready", 64'(cpu_req_ready), 64'd1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = v.addr;
    flush         = v.flush_acc;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    flush         = 1'b0;
    #1;
    check("lookup_ren", 64'(ram_ren), 64'(1) << wrd);
    check("lookup_ram_addr", 64'(ram_addr), 64'(idx));
    check("lookup_no_resp", 64'(cpu_resp_valid), 64'd0);
    @(negedge clk);
    if (cpu_resp_valid) begin
      data = cpu_resp_data;
      check("hit_no_mem_req", 64'(mem_req_valid), 64'd0);
      check("hit_ready", 64'(cpu_req_ready), 64'd1);
      return;
    end
    miss = 1'b1;
    check("mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("mem_req_addr", 64'(mem_req_addr), 64'(line));
    for (int i = 0; i < v.rdy; i++) begin
      @(negedge clk);
      check("mem_req_hold_valid", 64'(mem_req_valid), 64'd1);
      check("mem_req_hold_addr", 64'(mem_req_addr), 64'(line));
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("mem_req_drop", 64'(mem_req_valid), 64'd0);
    for (int p = 0; p < 4; p++) begin
      if (p == v.rbeat) begin
        srst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        srst_n = 1'b1;
        return;
      end
      for (int g = 0; g < v.gap; g++) begin
        #1;
        check("gap_no_wen", 64'(ram_wen), 64'd0);
        @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = pack_of(line, p);
      flush          = (p == v.fbeat);
      #1;
      check("beat_wen", 64'(ram_wen), 64'(1) << p);
      check("beat_ram_addr", 64'(ram_addr), 64'(idx));
      check("beat_wdata", ram_wdata, pack_of(line, p));
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
      flush          = 1'b0;
      if (p < 3) begin
        #1;
        check("no_early_resp", 64'(cpu_resp_valid), 64'd0);
      end
    end
    check("miss_resp_valid", 64'(cpu_resp_valid), 64'd1);
    check("miss_ready", 64'(cpu_req_ready), 64'd1);
    data = cpu_resp_data;
  endtask

  task automatic run(input vec_t v, input bit exp_hit);
    bit          miss;
    logic [63:0] d;
    int          wrd;
    wrd = int'((v.addr >> 3) & 32'h3);
    fetch(v, miss, d);
    check("hit_vs_miss", 64'(miss), 64'(!exp_hit));
    if (v.rbeat < 0) check("resp_data", d, pack_of(v.addr & ~32'h1F, wrd));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  vec_t tbl[$];

  initial begin
    bit   mh;
    vec_t v;
    total = 0;
    bad   = 0;

    tbl.push_back(mk(32'h048, 0, 0, 0, -1, -1, 0)); // cold miss, index 2 word 1
    tbl.push_back(mk(32'h058, 0, 0, 0, -1, -1, 1)); // hit word 3 of the same line
    tbl.push_back(mk(32'h848, 0, 1, 0, -1, -1, 0)); // conflict, tag 1
    tbl.push_back(mk(32'h048, 0, 0, 0, -1, -1, 0)); // evicted, misses again
    tbl.push_back(mk(32'h1A0, 0, 5, 3, -1, -1, 0)); // backpressure and beat gaps
    tbl.push_back(mk(32'h1B8, 0, 0, 0, -1, -1, 1));
    tbl.push_back(mk(32'h060, 0, 0, 0,  1, -1, 0)); // flush on second beat
    tbl.push_back(mk(32'h060, 0, 0, 1, -1, -1, 0)); // line stayed invalid
    tbl.push_back(mk(32'h048, 0, 0, 0, -1, -1, 0)); // earlier lines flushed too
    tbl.push_back(mk(32'h1A0, 0, 0, 0, -1, -1, 0));
    tbl.push_back(mk(32'h068, 0, 0, 0, -1, -1, 1));
    tbl.push_back(mk(32'h048, 1, 0, 0, -1, -1, 0)); // flush with acceptance forces a miss
    tbl.push_back(mk(32'h308, 0, 2, 1, -1,  2, 0)); // reset after two beats
    tbl.push_back(mk(32'h308, 0, 0, 0, -1, -1, 0)); // refetched after reset
    tbl.push_back(mk(32'h318, 0, 0, 0, -1, -1, 1));
    tbl.push_back(mk(32'h048, 0, 0, 0, -1, -1, 0)); // reset cleared index 2

    srst_n         = 1'b0;
    cpu_req_valid  = 1'b0;
    cpu_req_addr   = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    model_clear();
    for (int i = 0; i < 64; i++) ref_tag[i] = -1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    srst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(cpu_req_ready), 64'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      model_access(tbl[k], mh);
      run(tbl[k], tbl[k].exp_hit);
    end

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9) == 0) do_flush();
      v.addr      = (32'($urandom_range(3)) << 11) | (32'($urandom_range(3)) << 5)
                  | (32'($urandom_range(3)) << 3) | 32'($urandom_range(7));
      v.flush_acc = ($urandom_range(7) == 0);
      v.rdy       = int'($urandom_range(3));
      v.gap       = int'($urandom_range(2));
      v.fbeat     = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1;
      v.rbeat     = -1;
      v.exp_hit   = 1'b0;
      model_access(v, mh);
      run(v, mh);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
